// File: rtl/twenty_bit_serializer_pkg.sv
// Shared definitions for the 20-bit parallel-to-serial transmitter and its
// companion 20-bit register: default word width and serializer state codes.
package twenty_bit_serializer_pkg;

  localparam int DEFAULT_WIDTH = 20;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Bit counter width: enough to hold WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/twenty_bit_serializer_if.sv
// Load handshake and serial link of the serializer, bundled as one port.
// The serializer connects through slave; the producer/consumer side uses master.
interface twenty_bit_serializer_if
  import twenty_bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] d;
  logic             load_valid;
  logic             load_ready;
  logic             ser_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             busy;
  logic             done;

  modport master (
    output d, load_valid, ser_ready,
    input  load_ready, ser_data, ser_valid, busy, done
  );

  modport slave (
    input  d, load_valid, ser_ready,
    output load_ready, ser_data, ser_valid, busy, done
  );

endinterface

// File: rtl/twenty_bit_shift_register.sv
// WIDTH-bit shift register with async clear, parallel load and shift enable.
// MSB_FIRST selects whether bits leave from the top (shift left) or bottom.
module twenty_bit_shift_register
  import twenty_bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             out_bit
);

  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shreg_q;

  always_comb begin
    // NOTE: hold value assigned first so every path writes shreg_d; no latch.
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = d;
    end else if (shift_en) begin
      shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                          : {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking so every flop samples pre-edge values.
    if (!reset) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/twenty_bit_serializer.sv
// Parallel-to-serial transmitter: takes one word on a load handshake and
// sends it one bit per accepted beat, pulsing done after the last bit.
module twenty_bit_serializer
  import twenty_bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  twenty_bit_serializer_if.slave bus
);

  localparam int              CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_t          state_d;
  state_t          state_q;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   cnt_q;
  logic            armed_d;
  logic            armed_q;

  logic            load_ready;
  logic            ser_valid;
  logic            ser_data;
  logic            busy;
  logic            done;
  logic            load_fire;
  logic            beat_fire;
  logic            shift_bit;

  assign load_fire = bus.load_valid & load_ready;
  assign beat_fire = ser_valid & bus.ser_ready;

  // armed_q keeps load_ready low until the first edge after reset release.
  assign armed_d = 1'b1;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_fire) state_d = ST_SHIFT;
      ST_SHIFT: if (beat_fire && (cnt_q == '0)) state_d = ST_DONE;
      ST_DONE:  state_d = load_fire ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state only; ser_data comes from the shift register flops.
  always_comb begin
    load_ready = 1'b0;
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_ready = armed_q;
      end
      ST_SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = shift_bit;
        busy      = 1'b1;
      end
      ST_DONE: begin
        load_ready = armed_q;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

  // Remaining-beats counter: WIDTH-1 at load, zero on the final beat.
  always_comb begin
    cnt_d = cnt_q;
    if (load_fire) begin
      cnt_d = CNT_LAST;
    end else if (beat_fire && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The last beat also shifts, leaving the register all-zero for DONE/IDLE.
  twenty_bit_shift_register #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (load_fire),
    .shift_en (beat_fire),
    .d        (bus.d),
    .out_bit  (shift_bit)
  );

  assign bus.load_ready = load_ready;
  assign bus.ser_valid  = ser_valid;
  assign bus.ser_data   = ser_data;
  assign bus.busy       = busy;
  assign bus.done       = done;

endmodule

// File: tb/tb_twenty_bit_serializer.sv
// Bench for twenty_bit_serializer: MSB-first and LSB-first instances share
// stimulus and are compared each cycle against a bit-queue reference model.
module tb_twenty_bit_serializer;
  import twenty_bit_serializer_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         clk        = 1'b0;
  logic         reset      = 1'b1;
  logic [W-1:0] d          = '0;
  logic         load_valid = 1'b0;
  logic         ser_ready  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending bits of the word in flight, in send order.
  bit q_m[$];
  bit q_l[$];
  bit m_armed = 1'b0;
  bit m_done  = 1'b0;

  // Observations of the DUTs
  bit rx_m[$];
  bit rx_l[$];
  int loads_seen  = 0;
  int beats_seen  = 0;
  int ones_seen   = 0;
  int busy_cycles = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  twenty_bit_serializer_if #(.WIDTH(W)) bus_m ();
  twenty_bit_serializer_if #(.WIDTH(W)) bus_l ();

  assign bus_m.d          = d;
  assign bus_m.load_valid = load_valid;
  assign bus_m.ser_ready  = ser_ready;
  assign bus_l.d          = d;
  assign bus_l.load_valid = load_valid;
  assign bus_l.ser_ready  = ser_ready;

  twenty_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m.slave)
  );

  twenty_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model across one rising edge using the inputs the DUTs saw.
  task automatic model_step();
    bit ld;
    bit bt;
    if (!reset) return;
    ld = load_valid && m_armed && (q_m.size() == 0);
    bt = ser_ready && (q_m.size() != 0);
    m_done = 1'b0;
    if (bt) begin
      void'(q_m.pop_front());
      void'(q_l.pop_front());
      if (q_m.size() == 0) m_done = 1'b1;
    end
    if (ld) begin
      for (int i = W - 1; i >= 0; i--) q_m.push_back(d[i]);
      for (int i = 0; i < W; i++)      q_l.push_back(d[i]);
      loads_seen++;
    end
    m_armed = 1'b1;
  endtask

  task automatic compare_all();
    bit ev;
    ev = (q_m.size() != 0);
    check("m_ser_valid",  bus_m.ser_valid,  ev);
    check("l_ser_valid",  bus_l.ser_valid,  ev);
    check("m_ser_data",   bus_m.ser_data,   ev ? q_m[0] : 1'b0);
    check("l_ser_data",   bus_l.ser_data,   ev ? q_l[0] : 1'b0);
    check("m_busy",       bus_m.busy,       ev);
    check("l_busy",       bus_l.busy,       ev);
    check("m_done",       bus_m.done,       m_done);
    check("l_done",       bus_l.done,       m_done);
    check("m_load_ready", bus_m.load_ready, m_armed && !ev);
    check("l_load_ready", bus_l.load_ready, m_armed && !ev);
    if (bus_m.busy) busy_cycles++;
    if (bus_m.done) done_pulses++;
  endtask

  // Inputs are already set for the coming edge; record beats, then step.
  task automatic tick();
    if (bus_m.ser_valid && ser_ready) begin
      beats_seen++;
      rx_m.push_back(bus_m.ser_data);
      if (bus_m.ser_data) ones_seen++;
    end
    if (bus_l.ser_valid && ser_ready) rx_l.push_back(bus_l.ser_data);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  function automatic bit ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return ((k % 4) == 0) || ((k % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic logic [W-1:0] decode(input int off, input bit msb);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) v[W-1-i] = (off + i < rx_m.size()) ? rx_m[off + i] : 1'b0;
      else     v[i]     = (off + i < rx_l.size()) ? rx_l[off + i] : 1'b0;
    end
    return v;
  endfunction

  task automatic clear_obs();
    rx_m.delete();
    rx_l.delete();
    beats_seen  = 0;
    ones_seen   = 0;
    busy_cycles = 0;
    done_pulses = 0;
  endtask

  task automatic wait_loads(input int target, input int budget);
    int n;
    n = 0;
    while ((loads_seen < target) && (n < budget)) begin
      tick();
      n++;
    end
    check("load_taken", loads_seen, target);
  endtask

  task automatic drain(input int mode, input int budget);
    int k;
    k = 0;
    while ((q_m.size() != 0) && (k < budget)) begin
      ser_ready = ready_for(mode, k);
      k++;
      tick();
    end
    check("word_drained", q_m.size(), 0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int mode);
    d          = w;
    load_valid = 1'b1;
    wait_loads(loads_seen + 1, 20);
    load_valid = 1'b0;
    d          = W'($urandom());
    drain(mode, 2000);
    tick();
  endtask

  initial begin
    int gap;
    int lr_high;
    logic [W-1:0] w;

    #1 reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    #1 check("load_ready_held_after_release", bus_m.load_ready, 1'b0);
    tick();
    check("load_ready_first_edge", bus_m.load_ready, 1'b1);

    // 45 with continuous ready, checked on both bit orders
    clear_obs();
    send_word(W'(45), 0);
    check("w45_msb_word",   decode(0, 1'b1), W'(45));
    check("w45_lsb_word",   decode(0, 1'b0), W'(45));
    check("w45_busy_cycles", busy_cycles, W);
    check("w45_done_pulses", done_pulses, 1);

    // All ones under a 1,0,0,1 ready pattern
    clear_obs();
    send_word({W{1'b1}}, 1);
    check("ones_beats",       beats_seen,  W);
    check("ones_count",       ones_seen,   W);
    check("ones_done_pulses", done_pulses, 1);

    // Back-to-back 54 then 101 with load_valid held high
    clear_obs();
    ser_ready  = 1'b1;
    d          = W'(54);
    load_valid = 1'b1;
    wait_loads(loads_seen + 1, 20);
    d   = W'(101);
    gap = 0;
    for (int n = 0; (n < 100) && (loads_seen < 4); n++) begin
      tick();
      if (!bus_m.ser_valid) gap++;
    end
    check("b2b_second_load", loads_seen, 4);
    check("b2b_idle_gap",    gap, 1);
    load_valid = 1'b0;
    drain(0, 100);
    tick();
    check("b2b_first_msb",  decode(0, 1'b1), W'(54));
    check("b2b_second_msb", decode(W, 1'b1), W'(101));
    check("b2b_first_lsb",  decode(0, 1'b0), W'(54));
    check("b2b_second_lsb", decode(W, 1'b0), W'(101));

    // Load request of 105 ignored while 100 is in flight
    clear_obs();
    ser_ready  = 1'b1;
    d          = W'(100);
    load_valid = 1'b1;
    wait_loads(loads_seen + 1, 20);
    d       = W'(105);
    lr_high = 0;
    for (int n = 0; (n < 100) && (loads_seen < 6); n++) begin
      tick();
      if (bus_m.busy && bus_m.load_ready) lr_high++;
    end
    check("ignore_load_ready_low", lr_high, 0);
    check("ignore_first_done",     done_pulses, 1);
    load_valid = 1'b0;
    drain(0, 100);
    tick();
    check("ignore_stream_100", decode(0, 1'b1), W'(100));
    check("ignore_stream_105", decode(W, 1'b1), W'(105));

    // Asynchronous reset after beat 7
    clear_obs();
    ser_ready  = 1'b1;
    d          = W'($urandom());
    load_valid = 1'b1;
    wait_loads(loads_seen + 1, 20);
    load_valid = 1'b0;
    for (int n = 0; (n < 50) && (beats_seen < 7); n++) tick();
    check("rst_beats_before", beats_seen, 7);
    #2 reset = 1'b0;
    q_m.delete();
    q_l.delete();
    m_armed = 1'b0;
    m_done  = 1'b0;
    #1;
    check("rst_m_ser_valid",  bus_m.ser_valid,  1'b0);
    check("rst_m_busy",       bus_m.busy,       1'b0);
    check("rst_m_load_ready", bus_m.load_ready, 1'b0);
    check("rst_l_ser_data",   {31'b0, bus_l.ser_data}, 32'd0);
    check("rst_l_ser_valid",  bus_l.ser_valid,  1'b0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_no_done", done_pulses, 0);
    clear_obs();
    send_word('0, 0);
    check("zero_beats", beats_seen,  W);
    check("zero_ones",  ones_seen,   0);
    check("zero_done",  done_pulses, 1);

    // Random words, random backpressure, random idle gaps
    for (int r = 0; r < 25; r++) begin
      clear_obs();
      w = W'($urandom());
      repeat ($urandom_range(0, 2)) tick();
      send_word(w, 2);
      check("rand_msb_word", decode(0, 1'b1), w);
      check("rand_lsb_word", decode(0, 1'b0), w);
      check("rand_done",     done_pulses, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/twenty_bit_serializer.md
Name: twenty_bit_serializer

Overview:
Transmit-side counterpart of the 20-bit parallel register. It accepts one parallel word from a register output via a valid/ready load handshake. It then shifts the word out one bit per accepted beat on a serial valid/ready link. It sits between a 20-bit register in the CPU datapath and any bit-serial consumer, such as a debug/trace link or an off-chip shift chain.

Parameters:
WIDTH, 20, word width in bits; must be >= 2.
MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous active-low reset; 0 clears all state immediately.
d  input  WIDTH  parallel word to transmit; sampled only on a load handshake.
load_valid  input  1  producer has a word on d.
load_ready  output  1  block can accept a word (IDLE or DONE state).
ser_data  output  1  current serial bit.
ser_valid  output  1  ser_data is valid.
ser_ready  input  1  consumer accepts ser_data this cycle.
busy  output  1  a word is in flight (SHIFT state).
done  output  1  one-cycle pulse: the last bit of a word was accepted.

Behaviour:
- Reset (reset=0, async): state=IDLE; shift register=0; bit counter=0. Outputs: load_ready=0, ser_data=0, ser_valid=0, busy=0, done=0. load_ready rises on the first clk edge after reset deasserts.
- States:
  - IDLE: load_ready=1, ser_valid=0.
  - SHIFT: load_ready=0, ser_valid=1, busy=1.
  - DONE: done=1 for exactly one cycle, load_ready=1.
- Load: the handshake occurs on a rising edge with load_valid & load_ready.
  - The shift register captures d and the counter loads WIDTH-1.
  - Next state is SHIFT.
  - No other effect of d or load_valid.
- Latency: the first bit appears on ser_data with ser_valid=1 in the cycle after the load edge.
- Bit order:
  - MSB_FIRST=1: ser_data = shreg[WIDTH-1]; on each accepted beat shreg shifts left, filling with 0.
  - MSB_FIRST=0: ser_data = shreg[0]; shreg shifts right, filling with 0.
- Beat: ser_valid & ser_ready at a rising edge.
  - If counter != 0: shift, counter decrements.
  - If counter == 0: go to DONE.
- Backpressure: while ser_ready=0, ser_data and ser_valid hold their value with no shift. A stall of any length is legal.
- DONE:
  - Lasts one cycle; ser_valid=0, ser_data=0.
  - A load handshake in DONE goes directly to SHIFT, so back-to-back words have exactly one idle cycle between last and first bit.
  - Otherwise DONE goes to IDLE.
- Total throughput with ser_ready held at 1: WIDTH beats + 1 DONE cycle per word.
- load_valid during SHIFT is ignored (load_ready=0). The producer must hold its word, and d is not sampled.
- Reset mid-word: the word is discarded, done does not pulse, and outputs go to reset values immediately (async).
- ser_data is registered, never combinational from d. done and busy are decoded from state only.
- Unused/illegal state encodings recover to IDLE on the next edge.

Decomposition:
- Shared package/header: state encodings IDLE/SHIFT/DONE as localparams, and the default word width 20 (shared with the 20-bit register).
- One natural sub-module: twenty_bit_shift_register.
  - Contains the WIDTH-bit register with async active-low clear, parallel load, and shift-enable.
  - Direction is set by a parameter.
- The FSM and counter live in the top module.

Test Plan:
- Reset then load d=20'd45 (20'h0002D), MSB_FIRST=1, ser_ready=1:
  - ser_data over 20 beats = 0000 0000 0000 0010 1101.
  - done pulses once on the cycle after beat 20.
  - busy=1 for exactly 20 cycles.
- Same word with MSB_FIRST=0: bit stream = 1011 0100 0000 0000 0000 (LSB first).
- d=20'hFFFFF with ser_ready toggling 1,0,0,1 repeatedly:
  - Exactly 20 ones are transferred.
  - ser_data/ser_valid are stable during stalls.
  - done pulses only after the 20th accepted beat.
- Back-to-back words 20'd54 then 20'd101, with load_valid held high:
  - The second load is accepted in the DONE cycle.
  - One idle cycle separates the streams.
  - Both streams are bit-exact.
- During SHIFT of 20'd100, drive load_valid=1 with d=20'd105:
  - The stream remains 20'd100.
  - load_ready=0 throughout.
  - 20'd105 is accepted only after done.
- Assert reset=0 asynchronously mid-word (after beat 7), between clock edges:
  - Outputs clear immediately.
  - No done pulse occurs.
  - After release, a new word 20'd0 streams 20 zeros with done.
